sdram_wr_burst: RTL and testbench

Parametrised SDRAM write-burst engine; next generation of the single-bank, fixed-length write controller.
- Accepts a write job (start bank/row/column, length in bursts) and requests the command bus from the SDRAM arbiter.
- Streams data from a show-ahead write FIFO in bursts of BL beats.
- Crosses row and bank boundaries automatically.
- Yields to auto-refresh at burst boundaries, then resumes where it stopped.

---
 rtl/sdram_wr_burst.sv | 174 +++++++++++++++++
 tb/tb_sdram_wr_burst.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_burst.sv
// SDRAM write-burst engine: ACT, back-to-back BL-beat WR bursts, PRE; crosses row/bank boundaries and yields to refresh between bursts.
// Outputs are registered, so a command appears one cycle after its decision; the bus is held from grant until the job ends or a refresh yield.
module sdram_wr_burst #(
  parameter int DW     = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int BL     = 4,
  parameter int TRCD   = 3,
  parameter int TRP    = 3,
  parameter int LEN_W  = 16
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              wr_trig,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_req,
  input  logic              wr_en,
  input  logic              ref_req,
  output logic              wr_end,
  output logic              busy,
  output logic              done,
  output logic [3:0]        wr_cmd,
  output logic [ROW_W-1:0]  wr_addr,
  output logic [BANK_W-1:0] bank_addr,
  output logic [DW-1:0]     wr_data,
  output logic              wfifo_rd_en,
  input  logic [DW-1:0]     wfifo_rd_data
);

  localparam int AW      = BANK_W + ROW_W + COL_W;
  localparam int CNT_MAX = (TRCD > TRP) ? ((TRCD > BL) ? TRCD : BL) : ((TRP > BL) ? TRP : BL);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [ROW_W-1:0] A10      = ROW_W'(1) << 10;
  localparam logic [COL_W-1:0] COL_MASK = ~COL_W'(BL - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_WR, S_PRE} state_t;
  typedef enum logic [1:0] {C_FIN, C_YLD, C_ROW} cause_t;

  state_t           state;
  cause_t           cause;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    addr;
  logic [LEN_W-1:0] rem;
  logic [AW-1:0]    addr_nxt;

  // Full {bank,row,col} increment: column carry bumps the row, row carry bumps the bank.
  assign addr_nxt = addr + AW'(BL);
  assign wr_data  = wfifo_rd_data;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cause       <= C_FIN;
      cnt         <= '0;
      addr        <= '0;
      rem         <= '0;
      wr_req      <= 1'b0;
      wr_end      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_cmd      <= CMD_NOP;
      wr_addr     <= '0;
      bank_addr   <= '0;
      wfifo_rd_en <= 1'b0;
    end else begin
      wr_end <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          wr_cmd      <= CMD_NOP;
          wfifo_rd_en <= 1'b0;
          if (wr_trig && (wr_len != '0)) begin
            addr   <= {wr_bank, wr_row, wr_col & COL_MASK};
            rem    <= wr_len;
            busy   <= 1'b1;
            wr_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_en) begin
            wr_req    <= 1'b0;
            state     <= S_ACT;
            cnt       <= '0;
            wr_cmd    <= CMD_ACT;
            wr_addr   <= addr[COL_W +: ROW_W];
            bank_addr <= addr[AW-1 -: BANK_W];
          end
        end
        S_ACT: begin
          if (cnt == CNT_W'(TRCD)) begin
            state       <= S_WR;
            cnt         <= '0;
            wr_cmd      <= CMD_WR;
            wr_addr     <= ROW_W'(addr[COL_W-1:0]);
            wfifo_rd_en <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            wr_cmd <= CMD_NOP;
          end
        end
        S_WR: begin
          if (cnt == CNT_W'(BL - 1)) begin
            addr <= addr_nxt;
            rem  <= rem - 1'b1;
            cnt  <= '0;
            // Burst boundary: the only point where the job may stop, yield or cross a row.
            if ((rem == LEN_W'(1)) || ref_req || (addr_nxt[COL_W-1:0] == '0)) begin
              state       <= S_PRE;
              wr_cmd      <= CMD_PRE;
              wr_addr     <= A10;
              wfifo_rd_en <= 1'b0;
              if (rem == LEN_W'(1))
                cause <= C_FIN;
              else if (ref_req)
                cause <= C_YLD;
              else
                cause <= C_ROW;
            end else begin
              wr_cmd      <= CMD_WR;
              wr_addr     <= ROW_W'(addr_nxt[COL_W-1:0]);
              wfifo_rd_en <= 1'b1;
            end
          end else begin
            cnt         <= cnt + 1'b1;
            wr_cmd      <= CMD_NOP;
            wfifo_rd_en <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt == CNT_W'(TRP)) begin
            cnt <= '0;
            case (cause)
              C_FIN: begin
                wr_cmd <= CMD_NOP;
                wr_end <= 1'b1;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= S_IDLE;
              end
              C_YLD: begin
                wr_cmd <= CMD_NOP;
                wr_end <= 1'b1;
                wr_req <= 1'b1;
                state  <= S_REQ;
              end
              default: begin
                wr_cmd    <= CMD_ACT;
                wr_addr   <= addr[COL_W +: ROW_W];
                bank_addr <= addr[AW-1 -: BANK_W];
                state     <= S_ACT;
              end
            endcase
          end else begin
            cnt    <= cnt + 1'b1;
            wr_cmd <= CMD_NOP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Randomised bench for sdram_wr_burst: a job-level address model fills an event scoreboard that a negedge monitor drains.
module tb_sdram_wr_burst;
  localparam int DW = 16, ROW_W = 12, COL_W = 9, BANK_W = 2, BL = 4, TRCD = 3, TRP = 3, LEN_W = 16;
  localparam int AW = BANK_W + ROW_W + COL_W;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRC = 4'b0100, PRE = 4'b0010, END_K = 4'b1111;

  logic              sclk, reset, wr_trig, wr_req, wr_en, ref_req, wr_end, busy, done, wfifo_rd_en;
  logic [BANK_W-1:0] wr_bank, bank_addr;
  logic [ROW_W-1:0]  wr_row, wr_addr;
  logic [COL_W-1:0]  wr_col;
  logic [LEN_W-1:0]  wr_len;
  logic [3:0]        wr_cmd;
  logic [DW-1:0]     wr_data, fifo_head;

  sdram_wr_burst #(.DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BL(BL),
                   .TRCD(TRCD), .TRP(TRP), .LEN_W(LEN_W)) dut (
    .sclk(sclk), .reset(reset), .wr_trig(wr_trig), .wr_bank(wr_bank), .wr_row(wr_row),
    .wr_col(wr_col), .wr_len(wr_len), .wr_req(wr_req), .wr_en(wr_en), .ref_req(ref_req),
    .wr_end(wr_end), .busy(busy), .done(done), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .bank_addr(bank_addr), .wr_data(wr_data), .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(fifo_head));

  typedef struct packed {
    logic [3:0]        kind;
    logic [ROW_W-1:0]  addr;
    logic [BANK_W-1:0] bank;
    logic              dn;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] fifo_q[$];
  bit            yflags[$];
  int            wr_idx;
  int            checks = 0, errors = 0;
  int            cyc = 0;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void upd_head();
    fifo_head = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  function automatic void push_ev(input logic [3:0] k, input longint a, input longint b, input bit d);
    ev_t e;
    e.kind = k; e.addr = ROW_W'(a); e.bank = BANK_W'(b); e.dn = d;
    exp_q.push_back(e);
  endfunction

  // Job model: walk a flat {bank,row,col} address burst by burst and list the bus events that must appear.
  task automatic push_model(input int bank, input int row, input int col, input int len, input int ymask);
    longint a, amask;
    amask = (longint'(1) << AW) - 1;
    a = (longint'(bank) << (ROW_W + COL_W)) | (longint'(row) << COL_W) | longint'(col - (col % BL));
    push_ev(ACT, (a >> COL_W) % (1 << ROW_W), a >> (ROW_W + COL_W), 0);
    for (int k = 0; k < len; k++) begin
      push_ev(WRC, a % (1 << COL_W), a >> (ROW_W + COL_W), 0);
      a = (a + BL) & amask;
      if (k == len - 1) begin
        push_ev(PRE, 1024, 0, 0);
        push_ev(END_K, 0, 0, 1);
      end else if (ymask[k % 32]) begin
        push_ev(PRE, 1024, 0, 0);
        push_ev(END_K, 0, 0, 0);
        push_ev(ACT, (a >> COL_W) % (1 << ROW_W), a >> (ROW_W + COL_W), 0);
      end else if (a % (1 << COL_W) == 0) begin
        push_ev(PRE, 1024, 0, 0);
        push_ev(ACT, (a >> COL_W) % (1 << ROW_W), a >> (ROW_W + COL_W), 0);
      end
    end
    for (int i = 0; i < len * BL; i++) fifo_q.push_back(DW'($urandom));
    upd_head();
    yflags.delete();
    for (int k = 0; k < len; k++) yflags.push_back(ymask[k % 32]);
    wr_idx = 0;
  endtask

  task automatic trigger(input int bank, input int row, input int col, input int len);
    @(negedge sclk);
    wr_trig = 1'b1; wr_bank = BANK_W'(bank); wr_row = ROW_W'(row); wr_col = COL_W'(col); wr_len = LEN_W'(len);
    @(negedge sclk);
    wr_trig = 1'b0;
  endtask

  task automatic run_job(input int bank, input int row, input int col, input int len, input int ymask);
    bit finished;
    if (len != 0) push_model(bank, row, col, len, ymask);
    trigger(bank, row, col, len);
    if (len == 0) begin
      repeat (8) @(negedge sclk);
      check("len0_busy", busy, 0);
      check("len0_req", wr_req, 0);
      return;
    end
    finished = 0;
    for (int n = 0; n < 3000 && !finished; n++) begin
      @(negedge sclk);
      wr_trig = 1'b0;
      if (done) finished = 1;
      else if (busy && ($urandom % 16 == 0)) begin
        // Triggers while busy must leave the job untouched.
        wr_trig = 1'b1; wr_bank = BANK_W'($urandom); wr_row = ROW_W'($urandom);
        wr_col = COL_W'($urandom); wr_len = LEN_W'($urandom_range(1, 9));
      end
    end
    wr_trig = 1'b0;
    if (!finished) check("job_timeout", 0, 1);
    repeat (2) @(negedge sclk);
    check("events_left", exp_q.size(), 0);
    check("fifo_left", fifo_q.size(), 0);
  endtask

  // Arbiter: random grants while requested, random noise otherwise.
  initial begin
    wr_en = 1'b0;
    forever begin
      @(negedge sclk);
      wr_en = wr_req ? ($urandom % 3 == 0) : ($urandom % 5 == 0);
    end
  end

  // Monitor: pops one expected event per non-NOP command or wr_end pulse, checks spacing and beats.
  initial begin
    int last_act, last_wr, last_pre;
    bit have_wr, have_pre, end_since_pre;
    logic [3:0] prev;
    ev_t e;
    have_wr = 0; have_pre = 0; end_since_pre = 0; prev = NOP;
    last_act = 0; last_wr = 0; last_pre = 0;
    ref_req = 1'b0;
    forever begin
      @(negedge sclk);
      if (!reset) begin
        have_wr = 0; have_pre = 0; end_since_pre = 0; prev = NOP;
      end else begin
        if (wr_cmd != NOP) begin
          if (exp_q.size() == 0) check("unexpected_cmd", wr_cmd, NOP);
          else begin
            e = exp_q.pop_front();
            check("cmd", wr_cmd, e.kind);
            check("addr", wr_addr, e.addr);
            if (e.kind != PRE) check("bank", bank_addr, e.bank);
          end
          if (wr_cmd == ACT) begin
            check("req_in_act", wr_req, 0);
            if (have_pre && !end_since_pre) check("pre_to_act", cyc - last_pre, TRP + 1);
            last_act = cyc;
          end else if (wr_cmd == WRC) begin
            check("req_in_wr", wr_req, 0);
            if (prev == ACT) check("act_to_wr", cyc - last_act, TRCD + 1);
            else if (prev == WRC) check("wr_to_wr", cyc - last_wr, BL);
            last_wr = cyc; have_wr = 1;
            ref_req = (wr_idx < yflags.size()) ? yflags[wr_idx] : 1'b0;
            wr_idx++;
          end else if (wr_cmd == PRE) begin
            check("wr_to_pre", cyc - last_wr, BL);
            last_pre = cyc; have_pre = 1; end_since_pre = 0;
            ref_req = ($urandom % 2 == 0);
          end
          prev = wr_cmd;
        end
        check("rd_en", wfifo_rd_en, have_wr && (cyc - last_wr) < BL);
        if (wfifo_rd_en) begin
          if (fifo_q.size() == 0) check("fifo_underflow", 1, 0);
          else begin
            check("wr_data", wr_data, fifo_q[0]);
            void'(fifo_q.pop_front());
            upd_head();
          end
        end
        if (wr_end) begin
          if (exp_q.size() == 0) check("unexpected_end", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("end_kind", END_K, e.kind);
            check("done", done, e.dn);
            check("busy_at_end", busy, !e.dn);
          end
          if (have_pre) check("pre_to_end", cyc - last_pre, TRP + 1);
          end_since_pre = 1;
        end else if (done) check("done_without_end", 1, 0);
      end
    end
  end

  initial begin
    bit seen;
    reset = 1'b0; wr_trig = 1'b0; wr_bank = '0; wr_row = '0; wr_col = '0; wr_len = '0;
    fifo_head = '0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check("rst_cmd", wr_cmd, NOP);
    check("rst_addr", wr_addr, 0);
    check("rst_bank", bank_addr, 0);
    check("rst_flags", {wr_req, wr_end, busy, done, wfifo_rd_en}, 0);
    reset = 1'b1;

    run_job(0, 5, 0, 3, 0);
    run_job(0, 7, 508, 2, 0);
    run_job(1, 20, 0, 4, 32'b0010);
    run_job(3, 4095, 508, 2, 0);
    run_job(2, 3, 6, 2, 0);
    run_job(1, 2, 0, 2, 32'b0010);
    run_job(0, 1, 0, 0, 0);

    // Reset pulled in the middle of a WR burst.
    push_model(0, 10, 0, 4, 0);
    trigger(0, 10, 0, 4);
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge sclk);
      if (wr_cmd == WRC) seen = 1;
    end
    check("saw_wr_before_reset", seen, 1);
    @(negedge sclk);
    reset = 1'b0;
    @(posedge sclk); #1;
    check("mid_rst_cmd", wr_cmd, NOP);
    check("mid_rst_addr", {wr_addr, bank_addr}, 0);
    check("mid_rst_flags", {wr_req, wr_end, busy, done, wfifo_rd_en}, 0);
    exp_q.delete(); fifo_q.delete(); yflags.delete(); upd_head();
    @(negedge sclk);
    reset = 1'b1;
    run_job(2, 100, 40, 3, 0);

    for (int j = 0; j < 25; j++) begin
      int b, r, c, l, y;
      b = $urandom_range(0, 3);
      r = ($urandom % 3 == 0) ? 4095 : $urandom_range(0, 4095);
      c = ($urandom % 2 == 0) ? (512 - BL * $urandom_range(1, 3)) : $urandom_range(0, 511);
      l = $urandom_range(1, 8);
      y = int'($urandom & $urandom);
      run_job(b, r, c, l, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
